// File: rtl/seq_mult_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
// Consumed by seq_multiplier and seq_mult_abs.
package seq_mult_pkg;

  localparam int SEQ_MULT_WIDTH = 32;
  localparam int SEQ_MULT_CNT_W = $clog2(SEQ_MULT_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_abs.sv
// Conditional two's-complement negate: yields the magnitude of an operand when
// i_neg flags a negative value, and applies the sign correction to the product.
module seq_mult_abs
  import seq_mult_pkg::*;
#(
  parameter int W = SEQ_MULT_WIDTH
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier with a start/busy/done handshake.
// Optional build macro SEQ_MULT_EARLY_TERM_EN: leave RUN once the multiplier is exhausted.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_sign;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_acc;
  logic [PW-1:0]      r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [PW-1:0]      w_prod;
  logic               w_accept;
  logic               w_last;

  assign w_neg1   = signed_i & src1_i[WIDTH-1];
  assign w_neg2   = signed_i & src2_i[WIDTH-1];
  assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));

  seq_mult_abs #(.W(WIDTH)) u_abs_src1 (
    .i_val (src1_i),
    .i_neg (w_neg1),
    .o_val (w_mag1)
  );

  seq_mult_abs #(.W(WIDTH)) u_abs_src2 (
    .i_val (src2_i),
    .i_neg (w_neg2),
    .o_val (w_mag2)
  );

  // The magnitude product is at most 2^(2*WIDTH-2), so negating it is exact.
  seq_mult_abs #(.W(PW)) u_abs_prod (
    .i_val (r_acc),
    .i_neg (r_sign),
    .o_val (w_prod)
  );

  always_comb begin
    // NOTE: default first so every path assigns w_last and no latch is inferred.
    w_last = 1'b0;
    if (r_cnt == CNT_W'(WIDTH)) begin
      w_last = 1'b1;
    end
`ifdef SEQ_MULT_EARLY_TERM_EN
    else if ((r_cnt != '0) && (r_mplier == '0)) begin
      w_last = 1'b1;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sign   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_mag1};
            r_mplier <= w_mag2;
            r_sign   <= w_neg1 ^ w_neg2;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end

        S_RUN: begin
          if (w_last) begin
            r_hi    <= w_prod[PW-1:WIDTH];
            r_lo    <= w_prod[WIDTH-1:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            if (r_mplier[0]) begin
              r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign hi_o   = r_hi;
  assign lo_o   = r_lo;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed corner cases plus random
// operands against an arithmetic reference model of product and latency.
module tb_seq_multiplier;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic         signed_i;
  logic [W-1:0] src1_i;
  logic [W-1:0] src2_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .signed_i (signed_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                              input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // Edges from the accepting edge until done_o is visible.
  function automatic int model_lat(input logic [31:0] b, input logic s);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [31:0] mag;
    int k;
    mag = (s && b[31]) ? (~b + 32'd1) : b;
    k = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) k = i + 1;
    return ((k < 1) ? 1 : k) + 1;
`else
    return (s === 1'bx) ? 0 : W + 1;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input int inject_at);
    logic [63:0] prev;
    logic [63:0] exp_p;
    int lat, edges, busy_gaps;
    bit seen;
    exp_p = model_prod(a, b, s);
    lat   = model_lat(b, s);
    prev  = {hi_o, lo_o};
    @(negedge clk_i);
    start_i = 1'b1; signed_i = s; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0; src1_i = $urandom; src2_i = $urandom; signed_i = 1'($urandom);
    check({tag, " busy@accept"}, 64'(busy_o), 64'd1);
    check({tag, " done@accept"}, 64'(done_o), 64'd0);
    check({tag, " hold@accept"}, {hi_o, lo_o}, prev);
    edges = 0; seen = 1'b0; busy_gaps = 0;
    while (!seen && edges < 100) begin
      if (edges == inject_at - 1) begin
        start_i = 1'b1; src1_i = $urandom; src2_i = $urandom;
      end
      @(posedge clk_i); #1;
      edges++;
      start_i = 1'b0;
      if (done_o) seen = 1'b1;
      else if (!busy_o) busy_gaps++;
    end
    check({tag, " done seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " busy gaps"}, 64'(busy_gaps), 64'd0);
    check({tag, " product"}, {hi_o, lo_o}, exp_p);
    check({tag, " busy@done"}, 64'(busy_o), 64'd0);
  endtask

  task automatic idle_step(input string tag);
    logic [63:0] prev;
    prev = {hi_o, lo_o};
    @(posedge clk_i); #1;
    check({tag, " done drop"}, 64'(done_o), 64'd0);
    check({tag, " idle busy"}, 64'(busy_o), 64'd0);
    check({tag, " idle hold"}, {hi_o, lo_o}, prev);
  endtask

  initial begin
    int dones;
    logic [31:0] ra, rb;
    logic [15:0] imm;
    logic        rs;

    rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; src1_i = '0; src2_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset busy", 64'(busy_o), 64'd0);
    check("reset done", 64'(done_o), 64'd0);
    check("reset hilo", {hi_o, lo_o}, 64'd0);
    rst_i = 1'b0;

    run_op("u3x5", 32'd3, 32'd5, 1'b0, 0);
    check("u3x5 const", {hi_o, lo_o}, 64'h0000_0000_0000_000F);
    idle_step("u3x5");
    idle_step("u3x5 again");

    run_op("s-1x-1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    check("s-1x-1 const", {hi_o, lo_o}, 64'h0000_0000_0000_0001);
    check("done before b2b start", 64'(done_o), 64'd1);
    run_op("u-1x-1 b2b", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("u-1x-1 const", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);

    run_op("s min x2", 32'h8000_0000, 32'h0000_0002, 1'b1, 0);
    check("s min x2 const", {hi_o, lo_o}, 64'hFFFF_FFFF_0000_0000);
    run_op("s 7x-3", 32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 0);
    check("s 7x-3 const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    idle_step("s 7x-3");

    run_op("start in run", 32'h1234_5678, 32'h8765_4321, 1'b0, 5);
    idle_step("start in run");

    // Abort mid-operation with reset at E10.
    @(negedge clk_i);
    start_i = 1'b1; signed_i = 1'b0; src1_i = 32'hDEAD_BEEF; src2_i = 32'hFFFF_0001;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("abort busy", 64'(busy_o), 64'd0);
    check("abort done", 64'(done_o), 64'd0);
    check("abort hilo", {hi_o, lo_o}, 64'd0);
    dones = 0;
    repeat (50) begin
      @(posedge clk_i); #1;
      if (done_o) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    run_op("post reset", 32'h0001_0003, 32'h0000_0100, 1'b0, 0);

    run_op("u9x5", 32'd9, 32'd5, 1'b0, 0);
    check("u9x5 lo", 64'(lo_o), 64'd45);
    run_op("x0", 32'hCAFE_F00D, 32'd0, 1'b1, 0);
    check("x0 const", {hi_o, lo_o}, 64'd0);
    idle_step("x0");

    for (int i = 0; i < 16; i++) begin
      ra  = $urandom;
      rs  = 1'($urandom);
      imm = 16'($urandom);
      case (i % 3)
        0:       rb = $urandom;
        1:       rb = {{16{imm[15]}}, imm};
        default: rb = 32'($urandom_range(0, 255));
      endcase
      run_op($sformatf("rand%0d", i), ra, rb, rs, 0);
      if (i % 4 == 3) idle_step($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
